// File: rtl/adc_seq_pkg.sv
// Shared types and constants for the ADC request/ready sequencer.
package adc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        REQ_HI,
        REQ_LO,
        RECOVER
    } state_t;

    localparam int ADC_DAT_W      = 8;
    localparam int SAMPLE_CNT_W   = 16;
    localparam int ADC_RST_CYCLES = 2;

endpackage

// File: rtl/adc_rdy_sync.sv
// Two-flop synchronizer that brings the ADC's asynchronous ready into the clk domain.
module adc_rdy_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] sync_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], d};
        end
    end

    assign q = sync_reg[1];

endmodule

// File: rtl/adc_seq_ctrl.sv
// Fixed-rate ADC req/rdy sequencer with sample capture and timestamped threshold trigger.
// Optional handshake timeout/recovery is enabled by defining ADC_SEQ_TIMEOUT_EN.
module adc_seq_ctrl
    import adc_seq_pkg::*;
#(
    parameter int SAMPLE_DIV = 16,
    parameter int TIMEOUT    = 64,
    parameter int TS_W       = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    arm,
    input  logic [ADC_DAT_W-1:0]    trig_thresh,
    input  logic                    adc_rdy,
    input  logic [ADC_DAT_W-1:0]    adc_dat,
    output logic                    adc_req,
    output logic                    adc_rst,
    output logic [ADC_DAT_W-1:0]    sample,
    output logic                    sample_vld,
    output logic [SAMPLE_CNT_W-1:0] sample_cnt,
    output logic                    trig,
    output logic [TS_W-1:0]         trig_ts,
    output logic [ADC_DAT_W-1:0]    trig_sample,
    output logic                    busy,
    output logic                    err
);

    localparam int TICK_W = $clog2(SAMPLE_DIV);
    localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(SAMPLE_DIV - 1);
    localparam int RL_W = $clog2(ADC_RST_CYCLES + 1);

    if (SAMPLE_DIV < 8 || TIMEOUT < 2) begin : g_param_check
        $error("adc_seq_ctrl: SAMPLE_DIV must be >= 8 and TIMEOUT >= 2");
    end

    state_t                  state_reg, state_next;
    logic [TICK_W-1:0]       tick_reg, tick_next;
    logic                    stop_pend_reg, stop_pend_next;
    logic                    req_reg, req_next;
    logic [RL_W-1:0]         rst_left_reg, rst_left_next;
    logic                    adc_rst_reg, adc_rst_next;
    logic [ADC_DAT_W-1:0]    sample_reg, sample_next;
    logic                    vld_reg, vld_next;
    logic [SAMPLE_CNT_W-1:0] cnt_reg, cnt_next;
    logic                    armed_reg, armed_next;
    logic                    trig_reg, trig_next;
    logic [TS_W-1:0]         trig_ts_reg, trig_ts_next;
    logic [ADC_DAT_W-1:0]    trig_sample_reg, trig_sample_next;
    logic [TS_W-1:0]         ts_reg;
    logic                    rdy_s;
    logic                    capture;
    logic                    rec_load;
    logic                    clr_err;
    logic                    timeout_hit;

    adc_rdy_sync u_rdy_sync (
        .clk (clk),
        .rst (rst),
        .d   (adc_rdy),
        .q   (rdy_s)
    );

`ifdef ADC_SEQ_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT);
    logic [WAIT_W-1:0] wait_reg, wait_next;
    logic              err_reg;

    assign timeout_hit = (wait_reg == WAIT_W'(TIMEOUT - 1));

    // Wait counter restarts whenever the FSM changes state.
    always_comb begin
        wait_next = '0;
        if ((state_reg == REQ_HI || state_reg == REQ_LO) && state_next == state_reg) begin
            wait_next = wait_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_reg <= '0;
            err_reg  <= 1'b0;
        end else begin
            wait_reg <= wait_next;
            if (rec_load) begin
                err_reg <= 1'b1;
            end else if (clr_err) begin
                err_reg <= 1'b0;
            end
        end
    end

    assign err = err_reg;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_comb begin
        state_next       = state_reg;
        tick_next        = tick_reg;
        stop_pend_next   = stop_pend_reg | stop;
        req_next         = req_reg;
        sample_next      = sample_reg;
        vld_next         = 1'b0;
        cnt_next         = cnt_reg;
        armed_next       = armed_reg | arm;
        trig_next        = trig_reg & ~arm;
        trig_ts_next     = trig_ts_reg;
        trig_sample_next = trig_sample_reg;
        capture          = 1'b0;
        rec_load         = 1'b0;
        clr_err          = 1'b0;

        // Tick saturates at zero outside WAIT_TICK so an overrun yields one immediate request.
        if (state_reg != IDLE && tick_reg != '0) begin
            tick_next = tick_reg - 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (start && !stop) begin
                    state_next = WAIT_TICK;
                    tick_next  = TICK_RELOAD;
                    clr_err    = 1'b1;
                end
            end
            WAIT_TICK: begin
                if (stop_pend_next) begin
                    state_next = IDLE;
                end else if (tick_reg == '0) begin
                    state_next = REQ_HI;
                    req_next   = 1'b1;
                    tick_next  = TICK_RELOAD;
                end
            end
            REQ_HI: begin
                if (rdy_s) begin
                    capture    = 1'b1;
                    state_next = REQ_LO;
                end else if (timeout_hit) begin
                    rec_load   = 1'b1;
                    state_next = RECOVER;
                end
            end
            REQ_LO: begin
                if (!rdy_s) begin
                    state_next = stop_pend_next ? IDLE : WAIT_TICK;
                end else if (timeout_hit) begin
                    rec_load   = 1'b1;
                    state_next = RECOVER;
                end
            end
            RECOVER: begin
                if (rst_left_reg == '0) begin
                    state_next = stop_pend_next ? IDLE : WAIT_TICK;
                end
            end
            default: state_next = IDLE;
        endcase

        if (state_next == IDLE) begin
            stop_pend_next = 1'b0;
        end

        if (capture) begin
            sample_next = adc_dat;
            vld_next    = 1'b1;
            cnt_next    = cnt_reg + 1'b1;
            req_next    = 1'b0;
            // A firing capture overrides a same-cycle arm.
            if (armed_reg && adc_dat >= trig_thresh) begin
                trig_next        = 1'b1;
                trig_ts_next     = ts_reg;
                trig_sample_next = adc_dat;
                armed_next       = 1'b0;
            end
        end

        if (rec_load) begin
            req_next = 1'b0;
        end

        // One down-counter serves both the post-reset and the recovery adc_rst pulse.
        adc_rst_next  = rec_load | (rst_left_reg != '0);
        rst_left_next = rst_left_reg;
        if (rec_load) begin
            rst_left_next = RL_W'(ADC_RST_CYCLES - 1);
        end else if (rst_left_reg != '0) begin
            rst_left_next = rst_left_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            tick_reg        <= '0;
            stop_pend_reg   <= 1'b0;
            req_reg         <= 1'b0;
            rst_left_reg    <= RL_W'(ADC_RST_CYCLES);
            adc_rst_reg     <= 1'b0;
            sample_reg      <= '0;
            vld_reg         <= 1'b0;
            cnt_reg         <= '0;
            armed_reg       <= 1'b1;
            trig_reg        <= 1'b0;
            trig_ts_reg     <= '0;
            trig_sample_reg <= '0;
            ts_reg          <= '0;
        end else begin
            state_reg       <= state_next;
            tick_reg        <= tick_next;
            stop_pend_reg   <= stop_pend_next;
            req_reg         <= req_next;
            rst_left_reg    <= rst_left_next;
            adc_rst_reg     <= adc_rst_next;
            sample_reg      <= sample_next;
            vld_reg         <= vld_next;
            cnt_reg         <= cnt_next;
            armed_reg       <= armed_next;
            trig_reg        <= trig_next;
            trig_ts_reg     <= trig_ts_next;
            trig_sample_reg <= trig_sample_next;
            ts_reg          <= ts_reg + 1'b1;
        end
    end

    assign adc_req     = req_reg;
    assign adc_rst     = adc_rst_reg;
    assign sample      = sample_reg;
    assign sample_vld  = vld_reg;
    assign sample_cnt  = cnt_reg;
    assign trig        = trig_reg;
    assign trig_ts     = trig_ts_reg;
    assign trig_sample = trig_sample_reg;
    assign busy        = (state_reg != IDLE);

endmodule
